nes_pad_reader: RTL

Reads a physical NES controller (4021 shift-register pad) wired to spare FPGA pins and presents its buttons as an 8-bit active-high vector. The output uses the same bit order as the keyboard/USB joystick vectors that are OR-ed into `nes_joy_A`/`nes_joy_B`. It is the console side of the pad protocol: it drives latch and clock, samples serial data, and detects whether a pad is connected. One instance sits per port in the top level, on `clk` (~21.477 MHz).

---
 rtl/nes_pad_pkg.sv | 39 +++
 rtl/pad_sync.sv | 23 ++
 rtl/nes_pad_reader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/nes_pad_pkg.sv
// Shared state type, pad width and button bit positions for nes_pad_reader.
// Defining SNES_PAD_EN switches the reader to a 16-bit SNES pad.
package nes_pad_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } state_t;

`ifdef SNES_PAD_EN
    localparam int NBITS     = 16;
    localparam int BTN_B     = 0;
    localparam int BTN_Y     = 1;
    localparam int BTN_A     = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_L     = 10;
    localparam int BTN_R     = 11;
`else
    localparam int NBITS     = 8;
    localparam int BTN_A     = 0;
    localparam int BTN_B     = 1;
`endif
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // A floating port must never report phantom presses.
    function automatic logic [NBITS-1:0] gate_joy(input logic [NBITS-1:0] bits,
                                                  input logic present);
        return present ? bits : {NBITS{1'b0}};
    endfunction

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the asynchronous pad data line; idles high
// like the pulled-up line it watches.
module pad_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the pad line
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_r <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// Console side of the NES/SNES pad protocol: latches, clocks and samples the pad
// and reports buttons plus presence. SNES_PAD_EN selects the 16-bit SNES pad.
module nes_pad_reader
    import nes_pad_pkg::*;
#(
    parameter int HALF_CYC = 129,
    parameter int POLL_CYC = 357955
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             pad_data,
    output logic             pad_latch,
    output logic             pad_clk,
    output logic [NBITS-1:0] joy,
    output logic             present,
    output logic             valid
);

    localparam int PHW = $clog2(2 * HALF_CYC);
    localparam int POW = $clog2(POLL_CYC);
    localparam int BW  = $clog2(NBITS);

    localparam logic [PHW-1:0] LATCH_LAST = PHW'(2 * HALF_CYC - 1);
    localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_CYC - 1);
    localparam logic [POW-1:0] POLL_LAST  = POW'(POLL_CYC - 1);
    localparam logic [BW-1:0]  BIT_LAST   = BW'(NBITS - 1);

    state_t           state_r;
    logic [PHW-1:0]   phase_r;
    logic [BW-1:0]    bit_r;
    logic [POW-1:0]   poll_r;
    logic [NBITS-1:0] shift_r;
    logic             sync_q_s;
    logic             sample_s;

    pad_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pad_data),
        .q       (sync_q_s)
    );

    // Line low means pressed; the extra final sample low means a pad is present.
    assign sample_s = ~sync_q_s;

    // Free-running poll counter; only IDLE looks at it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            poll_r <= {POW{1'b0}};
        end else if (poll_r == POLL_LAST) begin
            poll_r <= {POW{1'b0}};
        end else begin
            poll_r <= poll_r + POW'(1);
        end
    end

    // Scan sequencer with registered pad pins and result outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            phase_r   <= {PHW{1'b0}};
            bit_r     <= {BW{1'b0}};
            shift_r   <= {NBITS{1'b0}};
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            joy       <= {NBITS{1'b0}};
            present   <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (poll_r == {POW{1'b0}} && en) begin
                        state_r   <= LATCH;
                        phase_r   <= {PHW{1'b0}};
                        bit_r     <= {BW{1'b0}};
                        pad_latch <= 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_r == LATCH_LAST) begin
                        shift_r   <= {sample_s, shift_r[NBITS-1:1]};
                        phase_r   <= {PHW{1'b0}};
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b0;
                        state_r   <= LOW;
                    end else begin
                        phase_r <= phase_r + PHW'(1);
                    end
                end
                LOW: begin
                    if (phase_r == HALF_LAST) begin
                        phase_r <= {PHW{1'b0}};
                        pad_clk <= 1'b1;
                        state_r <= HIGH;
                    end else begin
                        phase_r <= phase_r + PHW'(1);
                    end
                end
                HIGH: begin
                    if (phase_r == HALF_LAST) begin
                        phase_r <= {PHW{1'b0}};
                        if (bit_r == BIT_LAST) begin
                            // Last sample is the presence bit, not a button.
                            present <= sample_s;
                            joy     <= gate_joy(shift_r, sample_s);
                            valid   <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            shift_r <= {sample_s, shift_r[NBITS-1:1]};
                            bit_r   <= bit_r + BW'(1);
                            pad_clk <= 1'b0;
                            state_r <= LOW;
                        end
                    end else begin
                        phase_r <= phase_r + PHW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b1;
                end
            endcase
        end
    end

endmodule
